// File: rtl/arm_shift_pkg.sv
// Shared encodings and helpers for the ARM shifter_operand unit.
// Step size constant applies to builds with ARM_SHIFT_FAST_EN defined.
package arm_shift_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int AMT_W_DEF = 8;
  localparam int CNT_W     = 6;

  localparam logic [3:0] STEP_BIG   = 4'd8;
  localparam logic [3:0] STEP_SMALL = 4'd1;

  typedef enum logic [2:0] {
    SH_LSL = 3'b000,
    SH_LSR = 3'b001,
    SH_ASR = 3'b010,
    SH_ROR = 3'b011,
    SH_RRX = 3'b100
  } shift_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Reserved encodings fall back to LSL.
  function automatic shift_t norm_type(input logic [2:0] raw);
    if (raw <= 3'b100) begin
      return shift_t'(raw);
    end
    return SH_LSL;
  endfunction

  // Number of single-bit steps needed; the boundary results fall out of the iteration.
  function automatic logic [CNT_W-1:0] eff_count(input shift_t t,
                                                 input logic [AMT_W_DEF-1:0] amt);
    case (t)
      SH_LSL, SH_LSR: return (amt > 8'd33) ? 6'd33 : amt[CNT_W-1:0];
      SH_ASR:         return (amt > 8'd32) ? 6'd32 : amt[CNT_W-1:0];
      SH_ROR:         return ((amt != 8'd0) && (amt[4:0] == 5'd0)) ? 6'd32 : {1'b0, amt[4:0]};
      SH_RRX:         return 6'd1;
      default:        return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/arm_shift_step.sv
// One combinational shifter iteration: advances the word by 1 or 8 bit positions
// and reports the bit that left the word as the new carry.
module arm_shift_step
  import arm_shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] word,
  input  logic             carry,
  input  shift_t           shift_type,
  input  logic [3:0]       step_sz,
  output logic [WIDTH-1:0] next_word,
  output logic             next_carry
);

  logic                    big;
  logic signed [WIDTH-1:0] word_s;
  logic signed [WIDTH-1:0] asr_s;

  assign big    = (step_sz == STEP_BIG);
  assign word_s = word;
  assign asr_s  = big ? (word_s >>> 8) : (word_s >>> 1);

  always_comb begin
    next_word  = word;
    next_carry = carry;
    case (shift_type)
      SH_LSL: begin
        next_word  = big ? {word[WIDTH-9:0], 8'h00} : {word[WIDTH-2:0], 1'b0};
        next_carry = big ? word[WIDTH-8] : word[WIDTH-1];
      end
      SH_LSR: begin
        next_word  = big ? {8'h00, word[WIDTH-1:8]} : {1'b0, word[WIDTH-1:1]};
        next_carry = big ? word[7] : word[0];
      end
      SH_ASR: begin
        next_word  = asr_s;
        next_carry = big ? word[7] : word[0];
      end
      SH_ROR: begin
        next_word  = big ? {word[7:0], word[WIDTH-1:8]} : {word[0], word[WIDTH-1:1]};
        next_carry = next_word[WIDTH-1];
      end
      SH_RRX: begin
        next_word  = {carry, word[WIDTH-1:1]};
        next_carry = word[0];
      end
      default: begin
        next_word  = word;
        next_carry = carry;
      end
    endcase
  end

endmodule

// File: rtl/arm_shift_unit.sv
// Iterative ARM barrel shifter producing shifter_operand and shifter carry-out.
// Define ARM_SHIFT_FAST_EN to take 8-bit strides while at least 8 steps remain.
module arm_shift_unit
  import arm_shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic [AMT_W-1:0] amount,
  input  logic [2:0]       shift_type,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  state_t           state;
  shift_t           sh_type;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       step_sz;
  logic [WIDTH-1:0] step_word;
  logic             step_carry;

`ifdef ARM_SHIFT_FAST_EN
  assign step_sz = (cnt >= 6'd8) ? STEP_BIG : STEP_SMALL;
`else
  assign step_sz = STEP_SMALL;
`endif

  arm_shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .word      (result),
    .carry     (carry_out),
    .shift_type(sh_type),
    .step_sz   (step_sz),
    .next_word (step_word),
    .next_carry(step_carry)
  );

  // result/carry_out double as the working registers, so they hold once idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      sh_type   <= SH_LSL;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            result    <= value;
            carry_out <= carry_in;
            sh_type   <= norm_type(shift_type);
            cnt       <= eff_count(norm_type(shift_type), amount);
            busy      <= 1'b1;
            state     <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            result    <= step_word;
            carry_out <= step_carry;
            cnt       <= cnt - {2'b00, step_sz};
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arm_shift_unit.sv
// Self-checking bench for arm_shift_unit: directed plan cases, handshake cases
// and randomized operations against an architectural shifter model.
module tb_arm_shift_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] value;
  logic [7:0]  amount;
  logic [2:0]  shift_type;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arm_shift_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .value     (value),
    .amount    (amount),
    .shift_type(shift_type),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Architectural ARM shifter_operand rules, computed directly from the amount.
  function automatic void model(input logic [2:0] t_raw, input logic [31:0] v, input int amt,
                                input logic cin, output logic [31:0] r, output logic c);
    logic [2:0]  t;
    logic [31:0] tmp;
    logic [63:0] dbl;
    int          rot;
    t = (t_raw > 3'd4) ? 3'd0 : t_raw;
    r = v;
    c = cin;
    if (t == 3'd4) begin
      r = {cin, v[31:1]};
      c = v[0];
    end else if (amt != 0) begin
      case (t)
        3'd0: begin
          if (amt < 32) begin
            r = v << amt; tmp = v >> (32 - amt); c = tmp[0];
          end else if (amt == 32) begin
            r = 32'h0; c = v[0];
          end else begin
            r = 32'h0; c = 1'b0;
          end
        end
        3'd1: begin
          if (amt < 32) begin
            r = v >> amt; tmp = v >> (amt - 1); c = tmp[0];
          end else if (amt == 32) begin
            r = 32'h0; c = v[31];
          end else begin
            r = 32'h0; c = 1'b0;
          end
        end
        3'd2: begin
          if (amt < 32) begin
            r = 32'($signed(v) >>> amt); tmp = v >> (amt - 1); c = tmp[0];
          end else begin
            r = {32{v[31]}}; c = v[31];
          end
        end
        default: begin
          rot = amt % 32;
          if (rot == 0) begin
            r = v; c = v[31];
          end else begin
            dbl = {v, v} >> rot;
            r = dbl[31:0];
            tmp = v >> (rot - 1);
            c = tmp[0];
          end
        end
      endcase
    end
  endfunction

  function automatic int latency(input logic [2:0] t_raw, input int amt);
    int n;
    logic [2:0] t;
    t = (t_raw > 3'd4) ? 3'd0 : t_raw;
    case (t)
      3'd0, 3'd1: n = (amt > 33) ? 33 : amt;
      3'd2:       n = (amt > 32) ? 32 : amt;
      3'd3:       n = (amt == 0) ? 0 : (((amt % 32) == 0) ? 32 : (amt % 32));
      default:    n = 1;
    endcase
`ifdef ARM_SHIFT_FAST_EN
    return (n / 8) + (n % 8) + 1;
`else
    return n + 1;
`endif
  endfunction

  // Starts an operation immediately (back-to-back if called during a done cycle)
  // and returns in the cycle where done is observed.
  task automatic run_op(input string tag, input logic [2:0] t, input logic [31:0] v,
                        input int amt, input logic cin, input int poke_at);
    logic [31:0] er;
    logic        ec;
    int          lat;
    int          cycles;
    model(t, v, amt, cin, er, ec);
    lat = latency(t, amt);
    shift_type = t;
    value      = v;
    amount     = 8'(amt);
    carry_in   = cin;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    value      = $urandom;
    amount     = 8'($urandom);
    shift_type = 3'($urandom);
    carry_in   = 1'($urandom);
    chk({tag, ".busy_on"}, {31'b0, busy}, 32'd1);
    chk({tag, ".done_low"}, {31'b0, done}, 32'd0);
    cycles = 0;
    while (!done && cycles < 200) begin
      if (cycles == poke_at) begin
        start = 1'b1;
        value = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, 32'(cycles), 32'(lat));
    chk({tag, ".result"}, result, er);
    chk({tag, ".carry"}, {31'b0, carry_out}, {31'b0, ec});
    chk({tag, ".busy_off"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic seen_done;
    reset      = 1'b1;
    start      = 1'b0;
    value      = 32'hDEAD_BEEF;
    amount     = 8'd5;
    shift_type = 3'd0;
    carry_in   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", {31'b0, busy}, 32'd0);
    chk("rst.done", {31'b0, done}, 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.carry", {31'b0, carry_out}, 32'd0);
    reset = 1'b0;
    idle(1);

    run_op("lsl4", 3'd0, 32'h0000_0001, 4, 1'b0, -1);
    idle(1);
    chk("lsl4.done_pulse", {31'b0, done}, 32'd0);
    run_op("lsr32", 3'd1, 32'h8000_0001, 32, 1'b0, -1);
    idle(1);
    run_op("lsr33", 3'd1, 32'h8000_0001, 33, 1'b1, -1);
    idle(2);
    run_op("asr40", 3'd2, 32'h8000_0000, 40, 1'b0, -1);
    run_op("asr200", 3'd2, 32'h4000_0000, 200, 1'b1, -1);
    idle(1);
    run_op("ror4", 3'd3, 32'h0000_00F1, 4, 1'b1, -1);
    run_op("ror32", 3'd3, 32'h8000_0000, 32, 1'b0, -1);
    run_op("ror0", 3'd3, 32'h1234_5678, 0, 1'b1, -1);
    idle(1);
    run_op("rrx", 3'd4, 32'h0000_0003, 0, 1'b1, -1);
    run_op("inv111", 3'd7, 32'h0000_0003, 5, 1'b0, -1);
    run_op("lsl_by0", 3'd0, 32'hCAFE_F00D, 0, 1'b0, -1);
    idle(1);

    run_op("mid_start", 3'd0, 32'h0000_0001, 4, 1'b0, 2);
    run_op("b2b_a", 3'd1, 32'hF000_000F, 3, 1'b0, -1);
    run_op("b2b_b", 3'd2, 32'h8000_00F0, 9, 1'b0, -1);
    idle(1);

    shift_type = 3'd1;
    value      = 32'hFFFF_FFFF;
    amount     = 8'd20;
    carry_in   = 1'b1;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idle(3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst.busy", {31'b0, busy}, 32'd0);
    chk("midrst.done", {31'b0, done}, 32'd0);
    chk("midrst.result", result, 32'd0);
    chk("midrst.carry", {31'b0, carry_out}, 32'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    chk("midrst.no_done", {31'b0, seen_done}, 32'd0);
    run_op("post_rst", 3'd3, 32'hA5A5_0001, 37, 1'b0, -1);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  t;
      logic [31:0] v;
      int          amt;
      int          sel;
      t   = 3'($urandom_range(0, 7));
      v   = $urandom;
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       amt = int'($urandom_range(0, 40));
        1:       amt = int'($urandom_range(28, 36));
        2:       amt = int'($urandom_range(0, 255));
        default: amt = 32 * int'($urandom_range(0, 7));
      endcase
      run_op($sformatf("rnd%0d", i), t, v, amt, 1'($urandom), -1);
      idle(int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
